// File: rtl/nnet_vector_checker_if.sv
// DUT-facing channel of the vector checker: stimulus out (dat/vld), consume flag
// and response (dat/vld) back. master = checker side, slave = network top side.
interface nnet_vector_checker_if #(
  parameter int unsigned IN_W  = 180,
  parameter int unsigned OUT_W = 18
);
  logic [IN_W-1:0]  dut_in_dat;
  logic             dut_in_vld;
  logic             dut_in_triosy_lz;
  logic [OUT_W-1:0] dut_out_dat;
  logic             dut_out_vld;

  modport master (
    output dut_in_dat, dut_in_vld,
    input  dut_in_triosy_lz, dut_out_dat, dut_out_vld
  );

  modport slave (
    input  dut_in_dat, dut_in_vld,
    output dut_in_triosy_lz, dut_out_dat, dut_out_vld
  );
endinterface

// File: rtl/nnet_vector_checker.sv
// Buffered stimulus/response checker for HLS network tops: runs up to DEPTH
// (input, expected) pairs back-to-back with per-vector timeout and error capture.
module nnet_vector_checker #(
  parameter int unsigned IN_W    = 180,
  parameter int unsigned OUT_W   = 18,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned AW      = 4,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ld_we,
  input  logic [AW-1:0]        ld_addr,
  input  logic [IN_W-1:0]      ld_in,
  input  logic [OUT_W-1:0]     ld_exp,
  input  logic [AW:0]          num_vec,
  input  logic                 start,
  nnet_vector_checker_if.master dut,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 timeout,
  output logic [CNT_W-1:0]     err_cnt,
  output logic [AW-1:0]        first_err_idx,
  output logic [OUT_W-1:0]     first_err_val
);
  localparam int unsigned TW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_WAIT, S_NEXT, S_DONE} state_t;

  state_t           r_state, w_next;
  logic [IN_W-1:0]  r_mem_in  [DEPTH];
  logic [OUT_W-1:0] r_mem_exp [DEPTH];
  logic [AW-1:0]    r_idx;
  logic [AW:0]      r_num;
  logic [TW-1:0]    r_cnt;
  logic [IN_W-1:0]  r_dat;
  logic [CNT_W-1:0] r_err;
  logic             r_to;
  logic [AW-1:0]    r_fidx;
  logic [OUT_W-1:0] r_fval;

  logic w_idle, w_start, w_adv, w_expire, w_last, w_mismatch;

  assign w_idle     = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_start    = w_idle && start;
  assign w_adv      = ((r_state == S_DRIVE) && dut.dut_in_triosy_lz) ||
                      ((r_state == S_WAIT)  && dut.dut_out_vld);
  assign w_expire   = (r_cnt == TW'(TIMEOUT - 1));
  assign w_last     = ({1'b0, r_idx} == (r_num - (AW + 1)'(1)));
  assign w_mismatch = (dut.dut_out_dat != r_mem_exp[r_idx]);

  always_ff @(posedge clk) begin
    if (ld_we && w_idle) begin
      r_mem_in[ld_addr]  <= ld_in;
      r_mem_exp[ld_addr] <= ld_exp;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // A vector that advances on its final budgeted cycle is not a timeout.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start) w_next = (num_vec == '0) ? S_DONE : S_DRIVE;
      S_DRIVE:        if (dut.dut_in_triosy_lz) w_next = S_WAIT;
                      else if (w_expire)        w_next = S_DONE;
      S_WAIT:         if (dut.dut_out_vld)      w_next = S_NEXT;
                      else if (w_expire)        w_next = S_DONE;
      S_NEXT:         w_next = w_last ? S_DONE : S_DRIVE;
      default:        w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy           = 1'b0;
    done           = 1'b0;
    dut.dut_in_vld = 1'b0;
    case (r_state)
      S_DRIVE: begin
        busy           = 1'b1;
        dut.dut_in_vld = 1'b1;
      end
      S_WAIT, S_NEXT: busy = 1'b1;
      S_DONE:         done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx  <= '0;
      r_num  <= '0;
      r_cnt  <= '0;
      r_dat  <= '0;
      r_err  <= '0;
      r_to   <= 1'b0;
      r_fidx <= '0;
      r_fval <= '0;
    end else if (w_start) begin
      r_num  <= num_vec;
      r_idx  <= '0;
      r_cnt  <= '0;
      r_err  <= '0;
      r_to   <= 1'b0;
      r_fidx <= '0;
      r_fval <= '0;
      if (num_vec != '0) r_dat <= r_mem_in[0];
    end else begin
      case (r_state)
        S_DRIVE, S_WAIT: begin
          r_cnt <= r_cnt + TW'(1);
          if (w_expire && !w_adv) r_to <= 1'b1;
          // err_cnt never returns to zero mid-run, so zero marks the first mismatch.
          if ((r_state == S_WAIT) && dut.dut_out_vld && w_mismatch) begin
            if (r_err == '0) begin
              r_fidx <= r_idx;
              r_fval <= dut.dut_out_dat;
            end
            if (r_err != '1) r_err <= r_err + CNT_W'(1);
          end
        end
        S_NEXT: begin
          if (!w_last) begin
            r_idx <= r_idx + AW'(1);
            r_cnt <= '0;
            r_dat <= r_mem_in[r_idx + AW'(1)];
          end
        end
        default: ;
      endcase
    end
  end

  assign dut.dut_in_dat = r_dat;
  assign pass           = done && (r_err == '0) && !r_to;
  assign timeout        = r_to;
  assign err_cnt        = r_err;
  assign first_err_idx  = r_fidx;
  assign first_err_val  = r_fval;
endmodule
